// File: rtl/gray_event_counter_if.sv
// Event-counter bus: event qualifier, direction and clear toward the counter;
// registered Gray state, binary count and terminal-count pulse back.
interface gray_event_counter_if #(
    parameter int WIDTH = 3
);
    logic             in_i;
    logic             dir_i;
    logic             clr_i;
    logic [WIDTH-1:0] state_o;
    logic [WIDTH-1:0] count_o;
    logic             op_o;

    modport master (
        output in_i, dir_i, clr_i,
        input  state_o, count_o, op_o
    );

    modport slave (
        input  in_i, dir_i, clr_i,
        output state_o, count_o, op_o
    );
endinterface

// File: rtl/gray_event_counter.sv
// Gray-coded up/down event counter, modulo MODULUS, with a one-cycle
// terminal-count pulse on every wrap. The Gray state is registered alongside
// the binary count so it can be sampled safely from another clock domain.
// Optional macro GRAY_COUNTER_CONSECUTIVE_EN: an idle cycle (in=0) clears the
// count, turning the block into a run-length detector for consecutive events.
module gray_event_counter #(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gray_event_counter_if.slave   bus
);

    if (WIDTH < 2 || WIDTH > 16 || MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_param_check
        $error("gray_event_counter: WIDTH must be 2..16 and MODULUS 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] LAST   = WIDTH'(MODULUS - 1);
    // One bit wider than the count so the range check never degenerates
    // into a constant comparison when MODULUS == 2**WIDTH.
    localparam logic [WIDTH:0]   LAST_X = (WIDTH + 1)'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic             op_q, op_d;
    logic             illegal;

    assign illegal = ({1'b0, count_q} > LAST_X);

    // Next count and terminal pulse: clear, then recovery, then counting.
    always_comb begin
        count_d = count_q;
        op_d    = 1'b0;
        if (bus.clr_i) begin
            count_d = '0;
        end else if (illegal) begin
            count_d = '0;
        end else if (bus.in_i) begin
            if (bus.dir_i) begin
                if (count_q == LAST) begin
                    count_d = '0;
                    op_d    = 1'b1;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    count_d = LAST;
                    op_d    = 1'b1;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
`ifdef GRAY_COUNTER_CONSECUTIVE_EN
        else begin
            count_d = '0;
        end
`endif
        state_d = count_d ^ (count_d >> 1);
    end

    // Count, Gray state and pulse all update on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            state_q <= '0;
            op_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    assign bus.count_o = count_q;
    assign bus.state_o = state_q;
    assign bus.op_o    = op_q;

endmodule
